// File: rtl/sccb_write_master_if.sv
// Register-table handshake plus SCCB pin bundle for the OV2640 init writer.
// The master side serialises words; the slave side is the table and the bus observer.
interface sccb_write_master_if;
    logic [15:0] data_in;
    logic        reg_ok;
    logic        sccb_ok;
    logic        busy;
    logic        sio_c;
    logic        sio_d;
    logic        sio_d_oe;

    modport master (
        input  data_in, reg_ok,
        output sccb_ok, busy, sio_c, sio_d, sio_d_oe
    );

    modport slave (
        output data_in, reg_ok,
        input  sccb_ok, busy, sio_c, sio_d, sio_d_oe
    );
endinterface

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: sends one {reg_addr,reg_value} word per reg_ok and
// acknowledges completion with a one-clock sccb_ok pulse after a fixed post-STOP gap.
module sccb_write_master #(
    parameter logic [7:0]  DEV_ID       = 8'h60,
    parameter int unsigned QTR_DIV      = 125,
    parameter int unsigned GAP_QTRS     = 16,
    parameter int unsigned RST_GAP_QTRS = 4000
) (
    input  logic clk,
    input  logic rst_n,
    sccb_write_master_if.master bus
);
    localparam int unsigned QW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
    localparam int unsigned GW = 20;
    localparam int unsigned FW = 27;
    localparam logic [15:0] SOFT_RST_WORD = 16'h1280;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_STOP, S_GAP, S_DONE, S_HOLD
    } state_t;

    state_t        state, state_nxt;
    logic [QW-1:0] qtr_cnt, qtr_nxt;
    logic [1:0]    step, step_nxt;
    logic [4:0]    bit_idx, bit_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic          hold_cnt, hold_nxt;
    logic [15:0]   word, word_nxt;
    logic          c_nxt, d_nxt, oe_nxt, ok_nxt, busy_nxt;
    logic          tick_c;
    logic [GW-1:0] gap_len_c;
    logic [FW-1:0] frame_c;

    assign tick_c    = (qtr_cnt == QW'(QTR_DIV - 1));
    assign gap_len_c = (word == SOFT_RST_WORD) ? GW'(RST_GAP_QTRS) : GW'(GAP_QTRS);
    // Ninth bit of every byte is a released don't-care slot, driven as 1 for idle-high.
    assign frame_c   = {DEV_ID, 1'b1, word[15:8], 1'b1, word[7:0], 1'b1};

    // Next-state sequencing, then bus pins decoded from the quarter being entered.
    always_comb begin
        state_nxt = state;
        qtr_nxt   = '0;
        step_nxt  = step;
        bit_nxt   = bit_idx;
        gap_nxt   = gap_cnt;
        hold_nxt  = hold_cnt;
        word_nxt  = word;
        c_nxt     = 1'b1;
        d_nxt     = 1'b1;
        oe_nxt    = 1'b1;

        if (state inside {S_START, S_BIT, S_STOP, S_GAP})
            qtr_nxt = tick_c ? '0 : qtr_cnt + QW'(1);

        case (state)
            S_IDLE: begin
                if (bus.reg_ok) begin
                    state_nxt = S_START;
                    step_nxt  = 2'd0;
                    word_nxt  = bus.data_in;
                end
            end
            S_START: begin
                if (tick_c) begin
                    if (step == 2'd1) begin
                        state_nxt = S_BIT;
                        step_nxt  = 2'd0;
                        bit_nxt   = 5'd0;
                    end else begin
                        step_nxt = step + 2'd1;
                    end
                end
            end
            S_BIT: begin
                if (tick_c) begin
                    step_nxt = step + 2'd1;
                    if (step == 2'd3) begin
                        if (bit_idx == 5'(FW - 1)) begin
                            state_nxt = S_STOP;
                            step_nxt  = 2'd0;
                        end else begin
                            bit_nxt = bit_idx + 5'd1;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick_c) begin
                    if (step == 2'd2) begin
                        state_nxt = S_GAP;
                        gap_nxt   = '0;
                    end else begin
                        step_nxt = step + 2'd1;
                    end
                end
            end
            S_GAP: begin
                if (tick_c) begin
                    if (gap_cnt == gap_len_c - GW'(1)) state_nxt = S_DONE;
                    else                               gap_nxt   = gap_cnt + GW'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_HOLD;
                hold_nxt  = 1'b0;
            end
            S_HOLD: begin
                if (hold_cnt) state_nxt = S_IDLE;
                else          hold_nxt  = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase

        case (state_nxt)
            S_START: begin
                c_nxt = (step_nxt == 2'd0);
                d_nxt = 1'b0;
            end
            S_BIT: begin
                c_nxt  = (step_nxt == 2'd1) || (step_nxt == 2'd2);
                d_nxt  = frame_c[5'(FW - 1) - bit_nxt];
                oe_nxt = !((bit_nxt == 5'd8) || (bit_nxt == 5'd17) || (bit_nxt == 5'd26));
            end
            S_STOP: begin
                c_nxt = (step_nxt != 2'd0);
                d_nxt = (step_nxt == 2'd2);
            end
            default: ;
        endcase

        ok_nxt   = (state_nxt == S_DONE);
        busy_nxt = (state_nxt != S_IDLE);
    end

    // State, counters and registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            qtr_cnt      <= '0;
            step         <= '0;
            bit_idx      <= '0;
            gap_cnt      <= '0;
            hold_cnt     <= 1'b0;
            word         <= '0;
            bus.sio_c    <= 1'b1;
            bus.sio_d    <= 1'b1;
            bus.sio_d_oe <= 1'b1;
            bus.sccb_ok  <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            state        <= state_nxt;
            qtr_cnt      <= qtr_nxt;
            step         <= step_nxt;
            bit_idx      <= bit_nxt;
            gap_cnt      <= gap_nxt;
            hold_cnt     <= hold_nxt;
            word         <= word_nxt;
            bus.sio_c    <= c_nxt;
            bus.sio_d    <= d_nxt;
            bus.sio_d_oe <= oe_nxt;
            bus.sccb_ok  <= ok_nxt;
            bus.busy     <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench for sccb_write_master: decodes SIO_C/SIO_D, times sccb_ok and
// drives a small register-table model for the multi-word handshake.
module tb_sccb_write_master;
    localparam int unsigned QTR   = 4;
    localparam int unsigned GAPQ  = 4;
    localparam int unsigned RGAPQ = 40;
    localparam int unsigned RISES = 28;   // 27 bit clocks plus the STOP rise

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sccb_write_master_if bus();

    sccb_write_master #(
        .DEV_ID(8'h60), .QTR_DIV(QTR), .GAP_QTRS(GAPQ), .RST_GAP_QTRS(RGAPQ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [15:0] drv_data = 16'h0000;
    logic        drv_ok = 1'b0;
    bit          tbl_en = 1'b0;
    logic [15:0] tbl_data;
    logic        tbl_ok;
    int          tbl_cnt;
    logic [15:0] tbl_words [0:3] = '{16'hFF01, 16'h1280, 16'hFF00, 16'h0000};

    assign bus.data_in = tbl_en ? tbl_data : drv_data;
    assign bus.reg_ok  = tbl_en ? tbl_ok   : drv_ok;

    always @(posedge clk) cyc <= cyc + 1;

    // Register-init table: count advances on reg_ok&&sccb_ok, data_out registered from count.
    always @(posedge clk) begin
        if (!tbl_en) begin
            tbl_cnt  <= 0;
            tbl_ok   <= 1'b0;
            tbl_data <= tbl_words[0];
        end else begin
            if (tbl_ok && bus.sccb_ok) tbl_cnt <= tbl_cnt + 1;
            tbl_ok   <= (tbl_cnt < 3);
            tbl_data <= tbl_words[tbl_cnt[1:0]];
        end
    end

    logic bits[$];
    logic oes[$];
    int   starts, stops, ok_hi, ok_cyc, both_chg;
    bit   mon_en = 1'b1;
    logic prev_c = 1'b1;
    logic prev_d = 1'b1;

    // Bus observer sampling between edges.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.sio_c && !prev_c) begin
                bits.push_back(bus.sio_d);
                oes.push_back(bus.sio_d_oe);
            end
            if (bus.sio_c !== prev_c && bus.sio_d !== prev_d) both_chg++;
            if (bus.sio_c && prev_c && prev_d && !bus.sio_d) starts++;
            if (bus.sio_c && prev_c && !prev_d && bus.sio_d) stops++;
            if (bus.sccb_ok) begin
                ok_hi++;
                ok_cyc = cyc;
            end
        end
        prev_c = bus.sio_c;
        prev_d = bus.sio_d;
    end

    function automatic logic [7:0] get_byte(input int base);
        logic [7:0] b = '0;
        for (int i = 0; i < 8; i++) b = {b[6:0], bits[base + i]};
        return b;
    endfunction

    task automatic clear_mon();
        bits.delete();
        oes.delete();
        starts = 0; stops = 0; ok_hi = 0; ok_cyc = 0; both_chg = 0;
    endtask

    task automatic send_word(input logic [15:0] w, output int t0);
        @(negedge clk);
        drv_data = w;
        drv_ok   = 1'b1;
        @(negedge clk);
        t0       = cyc;
        drv_ok   = 1'b0;
        drv_data = 16'hA5A5;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((bus.busy || ok_hi == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_write(input string tag, input logic [15:0] w, input int t0,
                               input int lat);
        logic [7:0]  exp_b [3];
        logic [26:0] oe_v;
        exp_b = '{8'h60, w[15:8], w[7:0]};
        checks++;
        if (ok_hi !== 1) begin
            errors++; $display("FAIL %s ok_width got=%0d exp=1", tag, ok_hi);
        end
        checks++;
        if (ok_cyc - t0 !== lat) begin
            errors++; $display("FAIL %s latency got=%0d exp=%0d", tag, ok_cyc - t0, lat);
        end
        checks++;
        if (bits.size() !== RISES) begin
            errors++; $display("FAIL %s rise_count got=%0d exp=%0d", tag, bits.size(), RISES);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (get_byte(k * 9) !== exp_b[k]) begin
                    errors++;
                    $display("FAIL %s byte%0d got=%h exp=%h", tag, k, get_byte(k * 9), exp_b[k]);
                end
            end
            oe_v = '0;
            for (int i = 0; i < 27; i++) oe_v[26 - i] = oes[i];
            checks++;
            if (oe_v !== 27'b111111110_111111110_111111110) begin
                errors++; $display("FAIL %s oe_pattern got=%b", tag, oe_v);
            end
            checks++;
            if ({bits[8], bits[17], bits[26]} !== 3'b111) begin
                errors++; $display("FAIL %s ninth_sio_d got=%b exp=111", tag,
                                   {bits[8], bits[17], bits[26]});
            end
        end
        checks++;
        if (starts !== 1 || stops !== 1 || both_chg !== 0) begin
            errors++;
            $display("FAIL %s bus_shape start=%0d stop=%0d both_chg=%0d exp=1,1,0",
                     tag, starts, stops, both_chg);
        end
    endtask

    task automatic test_reset();
        int t0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.sio_c, bus.sio_d, bus.sio_d_oe, bus.sccb_ok, bus.busy} !== 5'b11100) begin
            errors++; $display("FAIL reset_vals got=%b exp=11100",
                {bus.sio_c, bus.sio_d, bus.sio_d_oe, bus.sccb_ok, bus.busy});
        end
        rst_n = 1'b1;
        clear_mon();
        send_word(16'h3C32, t0);
        repeat (86) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL reset_pre_busy got=%b exp=1", bus.busy);
        end
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.sio_c, bus.sio_d, bus.sio_d_oe, bus.sccb_ok, bus.busy} !== 5'b11100) begin
            errors++; $display("FAIL reset_async got=%b exp=11100",
                {bus.sio_c, bus.sio_d, bus.sio_d_oe, bus.sccb_ok, bus.busy});
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        mon_en = 1'b1;
        repeat (600) @(negedge clk);
        checks++;
        if (ok_hi !== 0 || bus.busy !== 1'b0 || bits.size() !== 0) begin
            errors++; $display("FAIL reset_dropped ok=%0d busy=%b rises=%0d exp=0,0,0",
                               ok_hi, bus.busy, bits.size());
        end
    endtask

    task automatic test_single_write();
        int t0;
        clear_mon();
        send_word(16'h3C32, t0);
        wait_idle(1000);
        check_write("single", 16'h3C32, t0, (113 + GAPQ) * QTR);
    endtask

    task automatic test_soft_reset();
        int t0;
        clear_mon();
        send_word(16'h1280, t0);
        wait_idle(1500);
        check_write("softrst", 16'h1280, t0, (113 + RGAPQ) * QTR);
    endtask

    task automatic test_table();
        logic [7:0] exp_b [9];
        int n = 0;
        exp_b = '{8'h60, 8'hFF, 8'h01, 8'h60, 8'h12, 8'h80, 8'h60, 8'hFF, 8'h00};
        clear_mon();
        tbl_en = 1'b1;
        repeat (3) @(negedge clk);
        while ((tbl_cnt < 3 || bus.busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if (tbl_cnt !== 3 || ok_hi !== 3) begin
            errors++; $display("FAIL table_count cnt=%0d ok=%0d exp=3,3", tbl_cnt, ok_hi);
        end
        checks++;
        if (bits.size() !== 3 * RISES) begin
            errors++; $display("FAIL table_rises got=%0d exp=%0d", bits.size(), 3 * RISES);
        end else begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (get_byte((k / 3) * RISES + (k % 3) * 9) !== exp_b[k]) begin
                    errors++; $display("FAIL table_byte%0d got=%h exp=%h", k,
                        get_byte((k / 3) * RISES + (k % 3) * 9), exp_b[k]);
                end
            end
        end
        checks++;
        if (starts !== 3 || stops !== 3 || both_chg !== 0) begin
            errors++; $display("FAIL table_shape start=%0d stop=%0d both_chg=%0d exp=3,3,0",
                               starts, stops, both_chg);
        end
        tbl_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_idle();
        int bad = 0;
        clear_mon();
        repeat (2000) begin
            @(negedge clk);
            if (bus.sio_c !== 1'b1 || bus.sio_d !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL idle_bus bad_cycles=%0d exp=0", bad);
        end
        checks++;
        if (ok_hi !== 0 || starts !== 0) begin
            errors++; $display("FAIL idle_ok ok=%0d start=%0d exp=0,0", ok_hi, starts);
        end
    endtask

    task automatic test_reset_mid_byte2();
        int t0;
        int n = 0;
        clear_mon();
        send_word(16'hABCD, t0);
        while (bits.size() < 12 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bits.size() !== 12) begin
            errors++; $display("FAIL midreset_reach rises=%0d exp=12", bits.size());
        end
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        mon_en = 1'b1;
        send_word(16'h1101, t0);
        wait_idle(1000);
        check_write("midreset", 16'h1101, t0, (113 + GAPQ) * QTR);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_soft_reset();
        test_table();
        test_idle();
        test_reset_mid_byte2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
